// File: rtl/digit_entry_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry_buffer_if
// Purpose  : Bundles the keypad-side inputs and the operand-side outputs of
//            digit_entry_buffer into one interface.
// Ports    : master -> drives keystrobe/keycode, observes buffer and result
//            slave  -> the entry buffer itself
//   keystrobe   key-valid level from the scanner
//   keycode     0-9 digit, A enter, B backspace, C clear, D negate, E/F none
//   digits      live BCD buffer, digit 0 in [3:0]
//   ndig        number of digits held
//   neg         live sign flag
//   isdig       1-cycle pulse, digit accepted
//   entered     1-cycle pulse, result updated
//   result      committed BCD value
//   result_neg  committed sign
//   overflow    1-cycle pulse, digit rejected (buffer full)
// Revision : 1.0 - initial release
// ============================================================================
interface digit_entry_buffer_if #(
  parameter int NDIGITS = 4
);
  localparam int CW = $clog2(NDIGITS + 1);

  logic                   keystrobe;
  logic [3:0]             keycode;
  logic [4*NDIGITS-1:0]   digits;
  logic [CW-1:0]          ndig;
  logic                   neg;
  logic                   isdig;
  logic                   entered;
  logic [4*NDIGITS-1:0]   result;
  logic                   result_neg;
  logic                   overflow;

  modport master (
    output keystrobe, keycode,
    input  digits, ndig, neg, isdig, entered, result, result_neg, overflow
  );

  modport slave (
    input  keystrobe, keycode,
    output digits, ndig, neg, isdig, entered, result, result_neg, overflow
  );
endinterface
`default_nettype wire

// File: rtl/digit_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry_buffer
// Purpose  : Multi-digit keypad entry buffer. Edge-detects the keypad strobe,
//            shifts decimal digits into an NDIGITS-wide BCD buffer, and
//            handles backspace, clear, sign toggle and enter. Enter commits a
//            signed BCD operand to the result outputs.
// Ports    : clk   system clock
//            nrst  asynchronous active-low reset
//            bus   digit_entry_buffer_if.slave (see interface header)
// Revision : 1.0 - initial release
// ============================================================================
module digit_entry_buffer #(
  parameter int NDIGITS = 4,
  parameter int CW      = $clog2(NDIGITS + 1)
) (
  input  wire                     clk,
  input  wire                     nrst,
  digit_entry_buffer_if.slave     bus
);

  localparam int DW = 4 * NDIGITS;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ks_q, ks_d;
  logic            armed_q, armed_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [CW-1:0]   ndig_q, ndig_d;
  logic            neg_q, neg_d;
  logic            isdig_q, isdig_d;
  logic            entered_q, entered_d;
  logic [DW-1:0]   result_q, result_d;
  logic            result_neg_q, result_neg_d;
  logic            overflow_q, overflow_d;

  logic            key_event;

  // A strobe that is already high when reset is released must not fire.
  // armed_q only becomes set once the strobe has been seen low, so the first
  // accepted event after reset is a genuine low-to-high transition.
  assign key_event = bus.keystrobe & ~ks_q & armed_q;

  always_comb begin
    ks_d         = bus.keystrobe;
    armed_d      = armed_q | ~bus.keystrobe;
    state_d      = state_q;
    digits_d     = digits_q;
    ndig_d       = ndig_q;
    neg_d        = neg_q;
    result_d     = result_q;
    result_neg_d = result_neg_q;
    isdig_d      = 1'b0;
    entered_d    = 1'b0;
    overflow_d   = 1'b0;

    if (key_event) begin
      if (bus.keycode <= 4'd9) begin
        case (state_q)
          EMPTY: begin
            isdig_d = 1'b1;
            // A leading zero is acknowledged but not stored.
            if (bus.keycode != 4'd0) begin
              digits_d = {{(DW-4){1'b0}}, bus.keycode};
              ndig_d   = CW'(1);
              state_d  = ENTRY;
            end
          end
          ENTRY: begin
            isdig_d  = 1'b1;
            digits_d = {digits_q[DW-5:0], bus.keycode};
            ndig_d   = ndig_q + CW'(1);
            if (ndig_q == CW'(NDIGITS - 1)) begin
              state_d = FULL;
            end
          end
          FULL: begin
            overflow_d = 1'b1;
          end
          default: begin
            state_d = EMPTY;
          end
        endcase
      end else begin
        case (bus.keycode)
          4'hA: begin
            result_d     = digits_q;
            // Never commit a negative zero.
            result_neg_d = neg_q & (ndig_q != '0);
            entered_d    = 1'b1;
            digits_d     = '0;
            ndig_d       = '0;
            neg_d        = 1'b0;
            state_d      = EMPTY;
          end
          4'hB: begin
            if (state_q == EMPTY) begin
              neg_d = 1'b0;
            end else begin
              digits_d = digits_q >> 4;
              ndig_d   = ndig_q - CW'(1);
              state_d  = (ndig_q == CW'(1)) ? EMPTY : ENTRY;
            end
          end
          4'hC: begin
            digits_d = '0;
            ndig_d   = '0;
            neg_d    = 1'b0;
            state_d  = EMPTY;
          end
          4'hD: begin
            neg_d = ~neg_q;
          end
          default: begin
            // E/F: ignored
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= EMPTY;
      ks_q         <= 1'b0;
      armed_q      <= 1'b0;
      digits_q     <= '0;
      ndig_q       <= '0;
      neg_q        <= 1'b0;
      isdig_q      <= 1'b0;
      entered_q    <= 1'b0;
      result_q     <= '0;
      result_neg_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ks_q         <= ks_d;
      armed_q      <= armed_d;
      digits_q     <= digits_d;
      ndig_q       <= ndig_d;
      neg_q        <= neg_d;
      isdig_q      <= isdig_d;
      entered_q    <= entered_d;
      result_q     <= result_d;
      result_neg_q <= result_neg_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.ndig       = ndig_q;
  assign bus.neg        = neg_q;
  assign bus.isdig      = isdig_q;
  assign bus.entered    = entered_q;
  assign bus.result     = result_q;
  assign bus.result_neg = result_neg_q;
  assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_entry_buffer
// Purpose  : Self-checking bench for digit_entry_buffer (NDIGITS=4) using a
//            queue-based reference model of the keypad entry rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_entry_buffer;
  localparam int NDIGITS = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  digit_entry_buffer_if #(.NDIGITS(NDIGITS)) bus ();

  digit_entry_buffer #(.NDIGITS(NDIGITS)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Reference model: held digits as a queue, most significant first.
  int       md[$];
  bit       mneg;
  bit [15:0] mres;
  bit       mres_neg;
  bit       m_isdig, m_ent, m_ovf;

  function automatic bit [15:0] pack();
    bit [15:0] v = 16'h0;
    foreach (md[i]) v = (v << 4) | 16'(md[i]);
    return v;
  endfunction

  function automatic logic [39:0] exp_vec();
    return {pack(), 3'(md.size()), mneg, m_isdig, m_ent, m_ovf, mres, mres_neg};
  endfunction

  function automatic logic [39:0] obs_vec();
    return {bus.digits, bus.ndig, bus.neg, bus.isdig, bus.entered, bus.overflow,
            bus.result, bus.result_neg};
  endfunction

  task automatic model_reset();
    md.delete(); mneg = 0; mres = 0; mres_neg = 0;
    m_isdig = 0; m_ent = 0; m_ovf = 0;
  endtask

  task automatic model_key(input int k);
    m_isdig = 0; m_ent = 0; m_ovf = 0;
    if (k <= 9) begin
      if (md.size() == NDIGITS) m_ovf = 1;
      else begin
        m_isdig = 1;
        if (!(md.size() == 0 && k == 0)) md.push_back(k);
      end
    end else if (k == 10) begin
      mres = pack(); mres_neg = mneg && (md.size() != 0); m_ent = 1;
      md.delete(); mneg = 0;
    end else if (k == 11) begin
      if (md.size() > 0) void'(md.pop_back());
      else mneg = 0;
    end else if (k == 12) begin
      md.delete(); mneg = 0;
    end else if (k == 13) begin
      mneg = ~mneg;
    end
  endtask

  // Raise the strobe for one event edge; outputs are sampled 1 time unit later.
  task automatic press(input int k);
    @(negedge clk);
    bus.keystrobe = 1'b1;
    bus.keycode   = 4'(k);
    @(posedge clk);
    model_key(k);
    #1;
  endtask

  task automatic release_key();
    @(negedge clk);
    bus.keystrobe = 1'b0;
    @(posedge clk);
    m_isdig = 0; m_ent = 0; m_ovf = 0;
    #1;
  endtask

  task automatic test_reset();
    bus.keystrobe = 1'b0;
    bus.keycode   = 4'h0;
    nrst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== 40'h0) $display("FAIL reset: got %h expected %h", obs_vec(), 40'h0);
    else passes++;
    @(negedge clk) nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_digits();
    int keys[3] = '{1, 2, 3};
    foreach (keys[i]) begin
      press(keys[i]);
      checks++;
      if (obs_vec() !== exp_vec() || bus.isdig !== 1'b1)
        $display("FAIL digit_press%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passes++;
      release_key();
      checks++;
      if (obs_vec() !== exp_vec() || bus.isdig !== 1'b0)
        $display("FAIL digit_pulse_end%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passes++;
    end
    checks++;
    if (bus.digits !== 16'h0123 || bus.ndig !== 3'd3)
      $display("FAIL digits_0123: got %h/%0d expected 0123/3", bus.digits, bus.ndig);
    else passes++;
  endtask

  task automatic test_held_strobe();
    int pulses = 0;
    press(12); release_key();
    @(negedge clk);
    bus.keystrobe = 1'b1;
    bus.keycode   = 4'd5;
    model_key(5);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.isdig === 1'b1) pulses++;
    end
    m_isdig = 0;
    checks++;
    if (pulses != 1) $display("FAIL held_strobe_pulses: got %0d expected 1", pulses);
    else passes++;
    checks++;
    if (obs_vec() !== exp_vec() || bus.digits !== 16'h0005 || bus.ndig !== 3'd1)
      $display("FAIL held_strobe_state: got %h expected %h", obs_vec(), exp_vec());
    else passes++;
    release_key();
  endtask

  task automatic test_leading_zero_overflow();
    int keys[8] = '{12, 0, 0, 7, 1, 2, 3, 4};
    foreach (keys[i]) begin
      press(keys[i]);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL lz_ovf_key%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passes++;
      if (i == 3) begin
        checks++;
        if (bus.digits !== 16'h0007 || bus.ndig !== 3'd1)
          $display("FAIL leading_zero: got %h/%0d expected 0007/1", bus.digits, bus.ndig);
        else passes++;
      end
      release_key();
    end
    checks++;
    if (bus.digits !== 16'h7123 || bus.ndig !== 3'd4 || m_ovf)
      $display("FAIL full_hold: got %h/%0d expected 7123/4", bus.digits, bus.ndig);
    else passes++;
  endtask

  task automatic test_enter_negate();
    int keys[8] = '{12, 9, 8, 13, 10, 13, 10, 15};
    foreach (keys[i]) begin
      press(keys[i]);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL enter_key%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passes++;
      if (i == 4) begin
        checks++;
        if (bus.result !== 16'h0098 || bus.result_neg !== 1'b1 || bus.entered !== 1'b1 ||
            bus.digits !== 16'h0 || bus.neg !== 1'b0)
          $display("FAIL enter_neg98: got %h/%b expected 0098/1", bus.result, bus.result_neg);
        else passes++;
      end
      if (i == 6) begin
        checks++;
        if (bus.result !== 16'h0 || bus.result_neg !== 1'b0)
          $display("FAIL enter_negzero: got %h/%b expected 0000/0", bus.result, bus.result_neg);
        else passes++;
      end
      release_key();
    end
  endtask

  task automatic test_backspace();
    int keys[8] = '{4, 5, 6, 11, 11, 11, 13, 11};
    foreach (keys[i]) begin
      press(keys[i]);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL bksp_key%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passes++;
      if (i == 4) begin
        checks++;
        if (bus.digits !== 16'h0004 || bus.ndig !== 3'd1)
          $display("FAIL bksp_0004: got %h/%0d expected 0004/1", bus.digits, bus.ndig);
        else passes++;
      end
      release_key();
    end
    checks++;
    if (bus.neg !== 1'b0 || bus.ndig !== 3'd0)
      $display("FAIL bksp_empty_neg: got %b/%0d expected 0/0", bus.neg, bus.ndig);
    else passes++;
  endtask

  task automatic test_reset_midstrobe();
    press(3); release_key();
    press(2); release_key();
    @(negedge clk);
    bus.keystrobe = 1'b1;
    bus.keycode   = 4'd7;
    #2 nrst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== 40'h0) $display("FAIL async_reset: got %h expected %h", obs_vec(), 40'h0);
    else passes++;
    @(negedge clk) nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== 40'h0) $display("FAIL held_after_reset: got %h expected %h", obs_vec(), 40'h0);
    else passes++;
    release_key();
    press(7);
    checks++;
    if (obs_vec() !== exp_vec() || bus.digits !== 16'h0007)
      $display("FAIL rearm_after_reset: got %h expected %h", obs_vec(), exp_vec());
    else passes++;
    release_key();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int k;
      // Bias toward digits so the buffer regularly fills.
      k = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
      press(k);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random_key%0d(code %0d): got %h expected %h", n, k, obs_vec(), exp_vec());
      else passes++;
      release_key();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random_idle%0d: got %h expected %h", n, obs_vec(), exp_vec());
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_held_strobe();
    test_leading_zero_overflow();
    test_enter_negate();
    test_backspace();
    test_reset_midstrobe();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
